// File: rtl/weighted_rr_burst_if.sv
// Request/weight bus from the requesters and the grant bus back from the arbiter.
// master = requester side, slave = arbiter side.
interface weighted_rr_burst_if #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 32
);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       request;
  logic [CHANNELS*WIDTH-1:0] weight;
  logic                      weight_load;
  logic [CHANNELS-1:0]       grant;
  logic [IW-1:0]             grant_idx;
  logic                      grant_valid;
  logic                      grant_last;

  modport master (
    output request, weight, weight_load,
    input  grant, grant_idx, grant_valid, grant_last
  );

  modport slave (
    input  request, weight, weight_load,
    output grant, grant_idx, grant_valid, grant_last
  );
endinterface

// File: rtl/weighted_rr_burst.sv
// Weighted round-robin burst arbiter: a winner keeps the grant for up to its weight in cycles.
// Grant registered one cycle after request; no backpressure, a dropped request ends the burst.
module weighted_rr_burst #(
  parameter int CHANNELS     = 8,
  parameter int WIDTH        = 32,
  parameter int WEIGHT_LIMIT = 16
) (
  input logic               clk,
  input logic               reset,
  weighted_rr_burst_if.slave bus
);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = $clog2(WEIGHT_LIMIT + 1);
  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(WEIGHT_LIMIT);
  localparam logic [CW-1:0]    LIMIT_C = CW'(WEIGHT_LIMIT);

  logic [WIDTH-1:0]    weight_q [CHANNELS];
  logic [CW-1:0]       eff      [CHANNELS];
  logic [CHANNELS-1:0] elig;
  logic [CHANNELS-1:0] grant_q;
  logic [IW-1:0]       idx_q;
  logic                vld_q;
  logic [CW-1:0]       credit_q;
  logic [IW-1:0]       ptr_q;

  logic                hold;
  logic                sel_found;
  logic [IW-1:0]       sel_idx;
  logic [CHANNELS-1:0] sel_oh;
  logic [IW-1:0]       ptr_nxt;

  // Clamp on the full-width weight so large values saturate instead of wrapping.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      eff[c]  = (weight_q[c] > LIMIT_W) ? LIMIT_C : weight_q[c][CW-1:0];
      elig[c] = bus.request[c] && (eff[c] != '0);
    end
  end

  assign hold = vld_q && bus.request[idx_q] && (credit_q > CW'(1));

  always_comb begin
    int j;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      j = int'(ptr_q) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!sel_found && elig[j]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(j);
      end
    end
    sel_oh          = '0;
    sel_oh[sel_idx] = 1'b1;
    ptr_nxt = (sel_idx == IW'(CHANNELS - 1)) ? '0 : sel_idx + IW'(1);
  end

  // Selection reads weight_q before this edge's load, so a same-edge load takes effect next time.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_q  <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      credit_q <= '0;
      ptr_q    <= '0;
      for (int c = 0; c < CHANNELS; c++) weight_q[c] <= WIDTH'(1);
    end else begin
      if (bus.weight_load) begin
        for (int c = 0; c < CHANNELS; c++) weight_q[c] <= bus.weight[c*WIDTH +: WIDTH];
      end
      if (hold) begin
        credit_q <= credit_q - CW'(1);
      end else if (sel_found) begin
        grant_q  <= sel_oh;
        idx_q    <= sel_idx;
        vld_q    <= 1'b1;
        credit_q <= eff[sel_idx];
        ptr_q    <= ptr_nxt;
      end else begin
        grant_q  <= '0;
        idx_q    <= '0;
        vld_q    <= 1'b0;
        credit_q <= '0;
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = vld_q;
  assign bus.grant_last  = vld_q && (credit_q == CW'(1));
endmodule

// File: tb/tb_weighted_rr_burst.sv
// Directed scenarios for weighted_rr_burst; expected grants are queued as each cycle is driven
// and compared after the following rising edge.
module tb_weighted_rr_burst;
  logic clk;
  logic reset;

  weighted_rr_burst_if #(.CHANNELS(8), .WIDTH(32)) bus ();

  weighted_rr_burst #(.CHANNELS(8), .WIDTH(32), .WEIGHT_LIMIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    idx;
    bit    vld;
    bit    last;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  task automatic set_w(input int w[8]);
    for (int c = 0; c < 8; c++) bus.weight[c*32 +: 32] = 32'(w[c]);
  endtask

  task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s %s got %0h expected %0h", tag, what, got, want);
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
  task automatic tick(input logic [7:0] req, input bit ld, input bit rst_n,
                      input int eidx, input bit evld, input bit elast, input string tag);
    exp_t       e;
    logic [7:0] eg;
    bus.request     = req;
    bus.weight_load = ld;
    reset           = rst_n;
    exp_q.push_back('{eidx, evld, elast, tag});
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    eg = e.vld ? (8'd1 << e.idx) : 8'd0;
    chk(e.tag, "grant",       32'(bus.grant),       32'(eg));
    chk(e.tag, "grant_idx",   32'(bus.grant_idx),   32'(e.idx));
    chk(e.tag, "grant_valid", 32'(bus.grant_valid), 32'(e.vld));
    chk(e.tag, "grant_last",  32'(bus.grant_last),  32'(e.last));
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    bus.request = '0;
    bus.weight = '0;
    bus.weight_load = 1'b0;

    tick(8'h00, 0, 0, 0, 0, 0, "reset0");
    tick(8'h00, 0, 0, 0, 0, 0, "reset1");

    // Plain round robin with default weights, through a full wrap.
    for (int k = 0; k < 16; k++) tick(8'hFF, 0, 1, k % 8, 1, 1, "rr");
    tick(8'h00, 0, 1, 0, 0, 0, "rr_idle");

    // Weighted bursts 3/1/2.
    set_w('{3, 1, 2, 0, 0, 0, 0, 0});
    tick(8'h00, 1, 1, 0, 0, 0, "w_load");
    tick(8'h07, 0, 1, 0, 1, 0, "w0a");
    tick(8'h07, 0, 1, 0, 1, 0, "w0b");
    tick(8'h07, 0, 1, 0, 1, 1, "w0c");
    tick(8'h07, 0, 1, 1, 1, 1, "w1");
    tick(8'h07, 0, 1, 2, 1, 0, "w2a");
    tick(8'h07, 0, 1, 2, 1, 1, "w2b");
    tick(8'h07, 0, 1, 0, 1, 0, "w0d");
    tick(8'h07, 0, 1, 0, 1, 0, "w0e");
    tick(8'h07, 0, 1, 0, 1, 1, "w0f");
    tick(8'h00, 0, 1, 0, 0, 0, "w_idle");

    // Clamp to 16; a mid-burst load must not disturb the running credit.
    set_w('{3, 1, 2, 100, 2, 0, 0, 0});
    tick(8'h00, 1, 1, 0, 0, 0, "clamp_load");
    set_w('{4, 1, 2, 2, 2, 1, 0, 0});
    for (int k = 1; k <= 16; k++)
      tick((k == 1) ? 8'h08 : 8'h18, k == 5, 1, 3, 1, k == 16, "clamp_ch3");
    tick(8'h18, 0, 1, 4, 1, 0, "ch4a");
    tick(8'h18, 0, 1, 4, 1, 1, "ch4b");
    tick(8'h18, 0, 1, 3, 1, 0, "ch3_new_a");
    tick(8'h18, 0, 1, 3, 1, 1, "ch3_new_b");
    tick(8'h00, 0, 1, 0, 0, 0, "clamp_idle");

    // Dropping the request ends the burst early.
    tick(8'h01, 0, 1, 0, 1, 0, "drop_a");
    tick(8'h21, 0, 1, 0, 1, 0, "drop_b");
    tick(8'h20, 0, 1, 5, 1, 1, "drop_ch5");
    tick(8'h00, 0, 1, 0, 0, 0, "drop_idle");

    // Zero weight disables a channel.
    for (int k = 0; k < 5; k++) tick(8'h40, 0, 1, 0, 0, 0, "zero_w");

    // Reset mid-burst overrides a concurrent load and restores weight 1.
    set_w('{4, 1, 5, 2, 2, 1, 0, 0});
    tick(8'h40, 1, 1, 0, 0, 0, "rst_load");
    tick(8'h04, 0, 1, 2, 1, 0, "rst_b2a");
    tick(8'h04, 0, 1, 2, 1, 0, "rst_b2b");
    tick(8'h04, 1, 0, 0, 0, 0, "rst_mid");
    tick(8'hFF, 0, 1, 0, 1, 1, "post_rst0");
    tick(8'hFF, 0, 1, 1, 1, 1, "post_rst1");
    tick(8'hFF, 0, 1, 2, 1, 1, "post_rst2");

    // Sole requester is re-granted back to back.
    for (int k = 0; k < 3; k++) tick(8'h02, 0, 1, 1, 1, 1, "sole");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
